// File: rtl/pm_pkg.sv
// pm_pkg: shared definitions for the instruction sequencer.
//   - 4-bit major opcodes (ir[15:12]) and 8-bit group opcodes (ir[15:8])
//   - sequencer state enum
//   - default reset and interrupt vectors
//   - modulo-4096 PC increment helper
package pm_pkg;

    // Major opcodes, ir[15:12]
    localparam logic [3:0] OP_LDA   = 4'h0;
    localparam logic [3:0] OP_LDB   = 4'h1;
    localparam logic [3:0] OP_STA   = 4'h2;
    localparam logic [3:0] OP_STB   = 4'h3;
    localparam logic [3:0] OP_JMP   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;
    localparam logic [3:0] OP_GRP   = 4'h7;
    localparam logic [3:0] OP_JSR   = 4'h8;
    localparam logic [3:0] OP_PUSHA = 4'hA;
    localparam logic [3:0] OP_POPA  = 4'hC;
    localparam logic [3:0] OP_RET   = 4'hE;

    // Group opcodes, ir[15:8] when ir[15:12] == 4'h7
    localparam logic [7:0] OP8_ADD  = 8'h71;
    localparam logic [7:0] OP8_AND  = 8'h72;
    localparam logic [7:0] OP8_CLA  = 8'h73;
    localparam logic [7:0] OP8_CLB  = 8'h74;
    localparam logic [7:0] OP8_CMB  = 8'h75;
    localparam logic [7:0] OP8_INCB = 8'h76;
    localparam logic [7:0] OP8_DECB = 8'h77;
    localparam logic [7:0] OP8_CLC  = 8'h78;
    localparam logic [7:0] OP8_CLZ  = 8'h79;
    localparam logic [7:0] OP8_ION  = 8'h7A;
    localparam logic [7:0] OP8_IOF  = 8'h7B;
    localparam logic [7:0] OP8_SC   = 8'h7C;
    localparam logic [7:0] OP8_SZ   = 8'h7D;

    localparam logic [11:0] PM_RESET_VECTOR = 12'h000;
    localparam logic [11:0] PM_ISR_VECTOR   = 12'hF00;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } pm_state_e;

    // 12-bit addition wraps naturally, giving modulo-4096 PC arithmetic.
    function automatic logic [11:0] pc_add(input logic [11:0] pc_val, input logic [11:0] n);
        return pc_val + n;
    endfunction

endpackage

// File: rtl/pm_sequencer_if.sv
// pm_sequencer_if: program-memory bus and execute-unit handshake.
//   pm_address     : sequencer -> program memory address
//   instruction_pm : program memory -> sequencer, combinational data
//   ir, ir_valid   : sequencer -> execute unit, issued instruction
//   ex_done        : execute unit -> sequencer, completion
//   flag_c, flag_z : execute unit -> sequencer, ALU flags for skips
interface pm_sequencer_if;
    logic [11:0] pm_address;
    logic [15:0] instruction_pm;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ex_done;
    logic        flag_c;
    logic        flag_z;

    modport master (
        output pm_address, ir, ir_valid,
        input  instruction_pm, ex_done, flag_c, flag_z
    );

    modport slave (
        input  pm_address, ir, ir_valid,
        output instruction_pm, ex_done, flag_c, flag_z
    );
endinterface

// File: rtl/pm_return_stack.sv
// pm_return_stack: register-file LIFO of 12-bit return addresses.
//   clk, rst_n : clock, asynchronous active-low reset (stack becomes empty)
//   push       : write push_data on top (ignored when full)
//   pop        : discard top entry (ignored when empty)
//   pop_data   : current top entry, combinational
//   full/empty : occupancy status
// push and pop are never requested together.
module pm_return_stack #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic [11:0] push_data,
    output logic [11:0] pop_data,
    output logic        full,
    output logic        empty
);
    localparam int PTR_W = $clog2(DEPTH);

    // Pointer has one extra bit so that a full stack (sp == DEPTH) is distinct from empty.
    logic [PTR_W:0]   sp_q, sp_d;
    logic [PTR_W-1:0] wr_idx, rd_idx;
    logic [11:0]      mem [DEPTH];

    assign wr_idx   = sp_q[PTR_W-1:0];
    assign rd_idx   = wr_idx - PTR_W'(1);
    assign full     = (sp_q == (PTR_W+1)'(DEPTH));
    assign empty    = (sp_q == '0);
    assign pop_data = mem[rd_idx];

    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + (PTR_W+1)'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage needs no reset: entries are only read below the stack pointer.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end
endmodule

// File: rtl/pm_sequencer.sv
// pm_sequencer: program counter, fetch and control-flow resolution.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : program-memory address/data and execute-unit handshake
//   irq        : level interrupt request, sampled in FETCH
//   ien        : interrupt-enable flag
//   pc         : program counter (also drives bus.pm_address)
//   halted     : sequencer stopped, leaves only through reset
//   stack_err  : sticky return-stack overflow/underflow
// JMP, JSR, RET, HALT, ION, IOF, SC and SZ are resolved here; every other
// opcode is issued to the execute unit and held until ex_done.
module pm_sequencer
    import pm_pkg::*;
#(
    parameter int          STACK_DEPTH  = 8,
    parameter logic [11:0] RESET_VECTOR = PM_RESET_VECTOR,
    parameter logic [11:0] ISR_VECTOR   = PM_ISR_VECTOR
) (
    input  logic          clk,
    input  logic          rst_n,
    pm_sequencer_if.master bus,
    input  logic          irq,
    output logic          ien,
    output logic [11:0]   pc,
    output logic          halted,
    output logic          stack_err
);
    pm_state_e   state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic        ien_q, ien_d;
    logic        stack_err_q, stack_err_d;

    logic        stk_push, stk_pop, stk_full, stk_empty;
    logic [11:0] stk_push_data, stk_pop_data;

    logic [3:0]  op4;
    logic [7:0]  op8;
    logic [11:0] target;
    logic [11:0] pc_inc1, pc_inc2;

    assign op4     = ir_q[15:12];
    assign op8     = ir_q[15:8];
    assign target  = ir_q[11:0];
    assign pc_inc1 = pc_add(pc_q, 12'd1);
    assign pc_inc2 = pc_add(pc_q, 12'd2);

    pm_return_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (stk_push_data),
        .pop_data  (stk_pop_data),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        ir_valid_d    = ir_valid_q;
        ien_d         = ien_q;
        stack_err_d   = stack_err_q;
        stk_push      = 1'b0;
        stk_pop       = 1'b0;
        stk_push_data = pc_inc1;

        case (state_q)
            ST_FETCH: begin
                // Interrupt entry takes a whole cycle and fetches nothing;
                // the next FETCH reads from the ISR vector.
                if (irq && ien_q && !stk_full) begin
                    stk_push      = 1'b1;
                    stk_push_data = pc_q;
                    pc_d          = ISR_VECTOR;
                    ien_d         = 1'b0;
                end else begin
                    ir_d    = bus.instruction_pm;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                state_d = ST_FETCH;
                case (op4)
                    OP_JMP: pc_d = target;
                    OP_JSR: begin
                        if (stk_full) begin
                            stack_err_d = 1'b1;
                            state_d     = ST_HALT;
                        end else begin
                            stk_push = 1'b1;
                            pc_d     = target;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            stack_err_d = 1'b1;
                            state_d     = ST_HALT;
                        end else begin
                            stk_pop = 1'b1;
                            pc_d    = stk_pop_data;
                        end
                    end
                    OP_HALT: state_d = ST_HALT;
                    OP_GRP: begin
                        case (op8)
                            OP8_ION: begin
                                ien_d = 1'b1;
                                pc_d  = pc_inc1;
                            end
                            OP8_IOF: begin
                                ien_d = 1'b0;
                                pc_d  = pc_inc1;
                            end
                            OP8_SC:  pc_d = bus.flag_c ? pc_inc2 : pc_inc1;
                            OP8_SZ:  pc_d = bus.flag_z ? pc_inc2 : pc_inc1;
                            default: begin
                                ir_valid_d = 1'b1;
                                state_d    = ST_EXEC;
                            end
                        endcase
                    end
                    default: begin
                        ir_valid_d = 1'b1;
                        state_d    = ST_EXEC;
                    end
                endcase
            end

            ST_EXEC: begin
                if (bus.ex_done) begin
                    ir_valid_d = 1'b0;
                    pc_d       = pc_inc1;
                    state_d    = ST_FETCH;
                end
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_VECTOR;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            ien_q       <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            ien_q       <= ien_d;
            stack_err_q <= stack_err_d;
        end
    end

    assign bus.pm_address = pc_q;
    assign bus.ir         = ir_q;
    assign bus.ir_valid   = ir_valid_q;
    assign pc             = pc_q;
    assign ien            = ien_q;
    assign halted         = (state_q == ST_HALT);
    assign stack_err      = stack_err_q;
endmodule

// File: tb/tb_pm_sequencer.sv
// tb_pm_sequencer: directed bench for pm_sequencer with a program-memory array.
module tb_pm_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        irq;
    logic        ien;
    logic [11:0] pc;
    logic        halted;
    logic        stack_err;
    logic [15:0] prog [4096];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pm_sequencer_if bus();

    assign bus.instruction_pm = prog[bus.pm_address];

    pm_sequencer #(
        .STACK_DEPTH  (8),
        .RESET_VECTOR (12'h000),
        .ISR_VECTOR   (12'hF00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.master),
        .irq       (irq),
        .ien       (ien),
        .pc        (pc),
        .halted    (halted),
        .stack_err (stack_err)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Fill memory with HALT so a runaway PC stops quickly.
    task automatic clear_prog();
        for (int i = 0; i < 4096; i++) prog[i] = 16'h5000;
    endtask

    // Pulse reset; returns at a falling edge with the sequencer in FETCH.
    task automatic start();
        irq = 1'b0; bus.ex_done = 1'b0; bus.flag_c = 1'b0; bus.flag_z = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; irq = 1'b0; bus.ex_done = 1'b0; bus.flag_c = 1'b0; bus.flag_z = 1'b0;
        clear_prog();
        #2;
        checks++; if (pc !== 12'h000) begin errors++; $display("FAIL reset_pc got %h expected %h", pc, 12'h000); end
        checks++; if (bus.pm_address !== 12'h000) begin errors++; $display("FAIL reset_pm_address got %h expected %h", bus.pm_address, 12'h000); end
        checks++; if (bus.ir !== 16'h0000) begin errors++; $display("FAIL reset_ir got %h expected %h", bus.ir, 16'h0000); end
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got %b expected 0", bus.ir_valid); end
        checks++; if (ien !== 1'b0) begin errors++; $display("FAIL reset_ien got %b expected 0", ien); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b expected 0", halted); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_stack_err got %b expected 0", stack_err); end
        $display("test_reset done");
    endtask

    // IOF, CLB, LDA 0x102, HALT at 0..3. CLB is not sequencer-owned, so it is issued.
    task automatic test_straight_line();
        clear_prog();
        prog[0] = 16'h7B00; prog[1] = 16'h7400; prog[2] = 16'h0102; prog[3] = 16'h5000;
        start();
        tick();
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL iof_decode_valid got %b expected 0", bus.ir_valid); end
        tick();
        checks++; if (pc !== 12'h001) begin errors++; $display("FAIL iof_pc got %h expected %h", pc, 12'h001); end
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL iof_valid got %b expected 0", bus.ir_valid); end
        ticks(2);
        checks++; if (bus.ir_valid !== 1'b1 || bus.ir !== 16'h7400) begin errors++; $display("FAIL clb_issue got valid %b ir %h expected valid 1 ir 7400", bus.ir_valid, bus.ir); end
        bus.ex_done = 1'b1; tick(); bus.ex_done = 1'b0;
        checks++; if (pc !== 12'h002 || bus.ir_valid !== 1'b0) begin errors++; $display("FAIL clb_done got pc %h valid %b expected pc 002 valid 0", pc, bus.ir_valid); end
        ticks(2);
        checks++; if (bus.ir_valid !== 1'b1 || bus.ir !== 16'h0102) begin errors++; $display("FAIL lda_issue got valid %b ir %h expected valid 1 ir 0102", bus.ir_valid, bus.ir); end
        ticks(3);
        checks++; if (bus.ir_valid !== 1'b1 || pc !== 12'h002) begin errors++; $display("FAIL lda_wait got valid %b pc %h expected valid 1 pc 002", bus.ir_valid, pc); end
        bus.ex_done = 1'b1; tick(); bus.ex_done = 1'b0;
        checks++; if (pc !== 12'h003 || bus.ir_valid !== 1'b0) begin errors++; $display("FAIL lda_done got pc %h valid %b expected pc 003 valid 0", pc, bus.ir_valid); end
        tick();
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL halt_decode_valid got %b expected 0", bus.ir_valid); end
        tick();
        checks++; if (halted !== 1'b1 || pc !== 12'h003) begin errors++; $display("FAIL halt_state got halted %b pc %h expected halted 1 pc 003", halted, pc); end
        bus.ex_done = 1'b1; ticks(3); bus.ex_done = 1'b0;
        checks++; if (halted !== 1'b1 || pc !== 12'h003 || bus.ir_valid !== 1'b0) begin errors++; $display("FAIL halt_frozen got halted %b pc %h valid %b expected 1 003 0", halted, pc, bus.ir_valid); end
        $display("test_straight_line done");
    endtask

    // SZ at 9, JMP 7 at 10; SC at 9 with carry set.
    task automatic test_skip_loop();
        clear_prog();
        prog[0] = 16'h4009; prog[9] = 16'h7D00; prog[10] = 16'h4007;
        start();
        ticks(2);
        checks++; if (pc !== 12'h009) begin errors++; $display("FAIL jmp9_pc got %h expected %h", pc, 12'h009); end
        ticks(2);
        checks++; if (pc !== 12'h00A) begin errors++; $display("FAIL sz0_pc got %h expected %h", pc, 12'h00A); end
        ticks(2);
        checks++; if (pc !== 12'h007) begin errors++; $display("FAIL jmp7_pc got %h expected %h", pc, 12'h007); end
        start();
        bus.flag_z = 1'b1;
        ticks(4);
        checks++; if (pc !== 12'h00B) begin errors++; $display("FAIL sz1_pc got %h expected %h", pc, 12'h00B); end
        prog[9] = 16'h7C00;
        start();
        bus.flag_c = 1'b1;
        ticks(4);
        checks++; if (pc !== 12'h00B) begin errors++; $display("FAIL sc1_pc got %h expected %h", pc, 12'h00B); end
        $display("test_skip_loop done");
    endtask

    // JSR 0x020 at 5, RET at 0x020.
    task automatic test_subroutine();
        clear_prog();
        prog[0] = 16'h4005; prog[5] = 16'h8020; prog[12'h020] = 16'hE000;
        start();
        ticks(2);
        checks++; if (pc !== 12'h005) begin errors++; $display("FAIL jmp5_pc got %h expected %h", pc, 12'h005); end
        ticks(2);
        checks++; if (pc !== 12'h020) begin errors++; $display("FAIL jsr_pc got %h expected %h", pc, 12'h020); end
        checks++; if (dut.u_stack.empty !== 1'b0) begin errors++; $display("FAIL jsr_stack_nonempty got empty %b expected 0", dut.u_stack.empty); end
        ticks(2);
        checks++; if (pc !== 12'h006) begin errors++; $display("FAIL ret_pc got %h expected %h", pc, 12'h006); end
        checks++; if (dut.u_stack.empty !== 1'b1) begin errors++; $display("FAIL ret_stack_empty got empty %b expected 1", dut.u_stack.empty); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL ret_stack_err got %b expected 0", stack_err); end
        $display("test_subroutine done");
    endtask

    // ION at 3 with irq held; ISR at 0xF00 runs ION then RET.
    task automatic test_interrupt();
        clear_prog();
        prog[0] = 16'h4003; prog[3] = 16'h7A00; prog[12'hF00] = 16'h7A00; prog[12'hF01] = 16'hE000;
        start();
        irq = 1'b1;
        ticks(2);
        checks++; if (pc !== 12'h003) begin errors++; $display("FAIL irq_masked_pc got %h expected %h", pc, 12'h003); end
        ticks(2);
        checks++; if (pc !== 12'h004 || ien !== 1'b1) begin errors++; $display("FAIL ion_state got pc %h ien %b expected pc 004 ien 1", pc, ien); end
        tick();
        checks++; if (pc !== 12'hF00 || ien !== 1'b0 || bus.ir_valid !== 1'b0) begin errors++; $display("FAIL irq_entry got pc %h ien %b valid %b expected F00 0 0", pc, ien, bus.ir_valid); end
        irq = 1'b0;
        ticks(2);
        checks++; if (pc !== 12'hF01 || ien !== 1'b1) begin errors++; $display("FAIL isr_ion got pc %h ien %b expected F01 1", pc, ien); end
        ticks(2);
        checks++; if (pc !== 12'h004 || ien !== 1'b1) begin errors++; $display("FAIL isr_ret got pc %h ien %b expected 004 1", pc, ien); end
        $display("test_interrupt done");
    endtask

    // Nine nested JSRs overflow an 8-deep stack; RET on empty underflows.
    task automatic test_stack_errors();
        clear_prog();
        for (int i = 0; i <= 8; i++) prog[i] = 16'h8000 | 16'(i + 1);
        start();
        for (int i = 0; i < 8; i++) begin
            ticks(2);
            checks++; if (pc !== 12'(i + 1) || halted !== 1'b0) begin errors++; $display("FAIL nest_jsr%0d got pc %h halted %b expected pc %h halted 0", i, pc, halted, 12'(i + 1)); end
        end
        ticks(2);
        checks++; if (stack_err !== 1'b1 || halted !== 1'b1 || pc !== 12'h008) begin errors++; $display("FAIL overflow got err %b halted %b pc %h expected 1 1 008", stack_err, halted, pc); end
        clear_prog();
        prog[0] = 16'hE000;
        start();
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b expected 0", stack_err); end
        ticks(2);
        checks++; if (stack_err !== 1'b1 || halted !== 1'b1 || pc !== 12'h000) begin errors++; $display("FAIL underflow got err %b halted %b pc %h expected 1 1 000", stack_err, halted, pc); end
        $display("test_stack_errors done");
    endtask

    // CLA and SC at 0xFFF wrap the PC; reset in EXEC abandons the instruction.
    task automatic test_wrap_and_reset();
        clear_prog();
        prog[0] = 16'h4FFF; prog[12'hFFF] = 16'h7300;
        start();
        ticks(4);
        checks++; if (bus.ir_valid !== 1'b1 || pc !== 12'hFFF) begin errors++; $display("FAIL cla_issue got valid %b pc %h expected 1 FFF", bus.ir_valid, pc); end
        bus.ex_done = 1'b1; tick(); bus.ex_done = 1'b0;
        checks++; if (pc !== 12'h000) begin errors++; $display("FAIL cla_wrap got %h expected %h", pc, 12'h000); end
        prog[12'hFFF] = 16'h7C00;
        start();
        bus.flag_c = 1'b1;
        ticks(4);
        checks++; if (pc !== 12'h001) begin errors++; $display("FAIL sc_wrap2 got %h expected %h", pc, 12'h001); end
        start();
        ticks(4);
        checks++; if (pc !== 12'h000) begin errors++; $display("FAIL sc_wrap1 got %h expected %h", pc, 12'h000); end
        clear_prog();
        prog[0] = 16'h4005; prog[5] = 16'h0102;
        start();
        ticks(4);
        checks++; if (bus.ir_valid !== 1'b1 || pc !== 12'h005) begin errors++; $display("FAIL pre_reset_exec got valid %b pc %h expected 1 005", bus.ir_valid, pc); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.ir_valid !== 1'b0 || pc !== 12'h000 || bus.ir !== 16'h0000) begin errors++; $display("FAIL async_reset got valid %b pc %h ir %h expected 0 000 0000", bus.ir_valid, pc, bus.ir); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_wrap_and_reset done");
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_skip_loop();
        test_subroutine();
        test_interrupt();
        test_stack_errors();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
